// File: rtl/vga_text_pkg.sv
// Shared constants and state types for the VGA text-mode RAM arbiter.
package vga_text_pkg;

  localparam int unsigned TEXT_COLS = 80;
  localparam int unsigned TEXT_ROWS = 30;
  localparam int unsigned CELL_W    = 8;
  localparam int unsigned CELL_H    = 16;
  localparam int unsigned H_VIS     = 640;
  localparam int unsigned V_VIS     = 480;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  // Who issued the RAM access whose data arrives on ram_rdata this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } ram_owner_e;

endpackage

// File: rtl/vga_cell_addr.sv
// Video slot detection and look-ahead cell address for the text prefetch.
module vga_cell_addr
  import vga_text_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic [15:0]       pixel_col,
  input  logic [15:0]       pixel_row,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              slot,
  output logic              load
);

  logic        visible;
  logic [15:0] text_col;
  logic [15:0] text_row;
  logic [15:0] next_row;
  logic [15:0] lin_addr;

  // Fetch one cell ahead; the last column of a line fetches column 0 of the next line.
  always_comb begin
    visible  = (pixel_col < 16'(H_VIS)) && (pixel_row < 16'(V_VIS));
    slot     = visible && ((pixel_col % 16'(CELL_W)) == 16'd0);
    load     = visible && ((pixel_col % 16'(CELL_W)) == 16'(CELL_W - 1));
    text_col = pixel_col / 16'(CELL_W);
    text_row = pixel_row / 16'(CELL_H);
    next_row = (pixel_row + 16'd1) / 16'(CELL_H);
    if (next_row >= 16'(TEXT_ROWS)) begin
      next_row = 16'd0;
    end
    if (text_col < 16'(TEXT_COLS - 1)) begin
      lin_addr = text_row * 16'(TEXT_COLS) + text_col + 16'd1;
    end else begin
      lin_addr = next_row * 16'(TEXT_COLS);
    end
    fetch_addr = ADDR_W'(lin_addr);
  end

endmodule

// File: rtl/vga_text_arbiter.sv
// Shares a single-port text RAM between the video prefetch (priority) and a CPU port.
module vga_text_arbiter
  import vga_text_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              pixel_clk,
  input  logic              data_reset_n,
  input  logic [15:0]       pixel_col,
  input  logic [15:0]       pixel_row,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] vid_cell
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  ram_owner_e        owner_q;
  ram_owner_e        owner_d;
  logic              issue;
  logic              slot;
  logic              load;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] prefetch_q;
  logic              cpu_rd_resp;

  vga_cell_addr #(
    .ADDR_W(ADDR_W)
  ) u_cell_addr (
    .pixel_col (pixel_col),
    .pixel_row (pixel_row),
    .fetch_addr(fetch_addr),
    .slot      (slot),
    .load      (load)
  );

  // Next state, RAM ownership and the combinational RAM command mux.
  always_comb begin
    state_d   = state_q;
    owner_d   = OWN_NONE;
    issue     = 1'b0;
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req && !slot) begin
          issue   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (slot) begin
      owner_d  = OWN_VID;
      ram_addr = fetch_addr;
    end else if (issue) begin
      owner_d   = OWN_CPU;
      ram_addr  = cpu_addr;
      ram_we    = cpu_we;
      ram_wdata = cpu_wdata;
    end
    // Reset must silence the RAM port even while the timing generator keeps running.
    if (!data_reset_n) begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
    end
  end

  // Read data is presented in the ack cycle, then held for the CPU afterwards.
  assign cpu_rd_resp = (owner_q == OWN_CPU) && !we_q;
  assign cpu_rdata   = cpu_rd_resp ? ram_rdata : rdata_q;

  always_ff @(posedge pixel_clk or negedge data_reset_n) begin
    if (!data_reset_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      cpu_ack    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      prefetch_q <= '0;
      vid_cell   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cpu_ack <= issue;
      if (slot || issue) begin
        addr_q <= ram_addr;
      end
      if (issue) begin
        we_q <= cpu_we;
      end
      if (cpu_rd_resp) begin
        rdata_q <= ram_rdata;
      end
      if (owner_q == OWN_VID) begin
        prefetch_q <= ram_rdata;
      end
      if (load) begin
        vid_cell <= prefetch_q;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Directed bench for vga_text_arbiter with a one-cycle-latency RAM model.
module tb_vga_text_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 12;

  logic              pixel_clk = 1'b0;
  logic              data_reset_n;
  logic [15:0]       pixel_col;
  logic [15:0]       pixel_row;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] vid_cell;

  logic [DATA_W-1:0] mem [4096];

  int errors = 0;
  int checks = 0;

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  vga_text_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .pixel_clk   (pixel_clk),
    .data_reset_n(data_reset_n),
    .pixel_col   (pixel_col),
    .pixel_row   (pixel_row),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .vid_cell    (vid_cell)
  );

  task automatic cyc(input logic [15:0] col, input logic [15:0] row);
    @(posedge pixel_clk);
    #1;
    pixel_col = col;
    pixel_row = row;
    #1;
  endtask

  task automatic test_reset();
    data_reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pixel_col = 16'd0; pixel_row = 16'd0;
    repeat (3) @(posedge pixel_clk);
    #1;
    checks++;
    if ({cpu_ack, cpu_rdata, vid_cell} !== 33'd0) begin
      errors++;
      $display("FAIL reset_cpu_vid: ack=%b rdata=%h vid=%h expected all 0", cpu_ack, cpu_rdata, vid_cell);
    end
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== 29'd0) begin
      errors++;
      $display("FAIL reset_ram: we=%b addr=%0d wdata=%h expected all 0", ram_we, ram_addr, ram_wdata);
    end
    @(posedge pixel_clk);
    #1;
    data_reset_n = 1'b1;
    pixel_col = 16'd700; pixel_row = 16'd500;
  endtask

  task automatic test_cpu_write();
    cyc(16'd2, 16'd32);
    cyc(16'd3, 16'd32);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd160; cpu_wdata = 16'h0148;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata, cpu_ack} !== {1'b1, 12'd160, 16'h0148, 1'b0}) begin
      errors++;
      $display("FAIL wr_issue: we=%b addr=%0d wdata=%h ack=%b expected 1/160/0148/0", ram_we, ram_addr, ram_wdata, cpu_ack);
    end
    cyc(16'd4, 16'd32);
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL wr_ack: ack=%b expected 1", cpu_ack);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc(16'd5, 16'd32);
    checks++;
    if ({cpu_ack, ram_we, ram_addr, ram_wdata} !== {1'b0, 1'b0, 12'd160, 16'h0000}) begin
      errors++;
      $display("FAIL idle_hold: ack=%b we=%b addr=%0d wdata=%h expected 0/0/160/0000", cpu_ack, ram_we, ram_addr, ram_wdata);
    end
    cyc(16'd6, 16'd32);
    cpu_req = 1'b1;
    #1;
    checks++;
    if ({ram_we, ram_addr} !== {1'b0, 12'd160}) begin
      errors++;
      $display("FAIL rd_issue: we=%b addr=%0d expected 0/160", ram_we, ram_addr);
    end
    cyc(16'd7, 16'd32);
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h0148}) begin
      errors++;
      $display("FAIL readback: ack=%b rdata=%h expected 1/0148", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_load();
    logic [ADDR_W-1:0] a [3] = '{12'd161, 12'd162, 12'd163};
    logic [DATA_W-1:0] d [3] = '{16'h0265, 16'h1234, 16'h5a5a};
    logic [15:0] col = 16'd100;
    cyc(col, 16'd500);
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a[i]; cpu_wdata = d[i];
      #1;
      checks++;
      if ({ram_we, ram_addr, ram_wdata} !== {1'b1, a[i], d[i]}) begin
        errors++;
        $display("FAIL load_issue%0d: we=%b addr=%0d wdata=%h expected 1/%0d/%h", i, ram_we, ram_addr, ram_wdata, a[i], d[i]);
      end
      col++;
      cyc(col, 16'd500);
      checks++;
      if (cpu_ack !== 1'b1) begin
        errors++;
        $display("FAIL load_ack%0d: ack=%b expected 1", i, cpu_ack);
      end
      cpu_req = 1'b0; cpu_we = 1'b0;
      col++;
      cyc(col, 16'd500);
    end
  endtask

  task automatic test_fetch();
    cyc(16'd0, 16'd32);
    checks++;
    if ({ram_we, ram_addr} !== {1'b0, 12'd161}) begin
      errors++;
      $display("FAIL fetch_addr: we=%b addr=%0d expected 0/161", ram_we, ram_addr);
    end
    for (int c = 1; c < 8; c++) cyc(16'(c), 16'd32);
    for (int c = 8; c < 16; c++) begin
      cyc(16'(c), 16'd32);
      checks++;
      if (vid_cell !== 16'h0265) begin
        errors++;
        $display("FAIL vid_cell_col%0d: got %h expected 0265", c, vid_cell);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0]       cols [7] = '{16'd632, 16'd0, 16'd632, 16'd632, 16'd640, 16'd8, 16'd0};
    logic [15:0]       rows [7] = '{16'd479, 16'd479, 16'd0, 16'd15, 16'd0, 16'd0, 16'd480};
    logic [ADDR_W-1:0] exp  [7] = '{12'd0, 12'd2321, 12'd0, 12'd80, 12'd80, 12'd2, 12'd2};
    for (int i = 0; i < 7; i++) begin
      cyc(cols[i], rows[i]);
      checks++;
      if ({ram_we, ram_addr} !== {1'b0, exp[i]}) begin
        errors++;
        $display("FAIL wrap_r%0d_c%0d: we=%b addr=%0d expected 0/%0d", rows[i], cols[i], ram_we, ram_addr, exp[i]);
      end
    end
  endtask

  task automatic test_resp_slot();
    cyc(16'd7, 16'd32);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd161;
    #1;
    checks++;
    if ({ram_we, ram_addr} !== {1'b0, 12'd161}) begin
      errors++;
      $display("FAIL rs_issue: we=%b addr=%0d expected 0/161", ram_we, ram_addr);
    end
    cyc(16'd8, 16'd32);
    checks++;
    if ({ram_addr, cpu_ack, cpu_rdata} !== {12'd162, 1'b1, 16'h0265}) begin
      errors++;
      $display("FAIL rs_ack: addr=%0d ack=%b rdata=%h expected 162/1/0265", ram_addr, cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    for (int c = 9; c < 17; c++) cyc(16'(c), 16'd32);
    checks++;
    if (vid_cell !== 16'h1234) begin
      errors++;
      $display("FAIL rs_vid: got %h expected 1234", vid_cell);
    end
  endtask

  task automatic test_stall();
    cyc(16'd8, 16'd32);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd163;
    #1;
    checks++;
    if ({ram_we, ram_addr, cpu_ack} !== {1'b0, 12'd162, 1'b0}) begin
      errors++;
      $display("FAIL stall_slot: we=%b addr=%0d ack=%b expected 0/162/0", ram_we, ram_addr, cpu_ack);
    end
    cyc(16'd9, 16'd32);
    checks++;
    if ({ram_we, ram_addr, cpu_ack} !== {1'b0, 12'd163, 1'b0}) begin
      errors++;
      $display("FAIL stall_issue: we=%b addr=%0d ack=%b expected 0/163/0", ram_we, ram_addr, cpu_ack);
    end
    cyc(16'd10, 16'd32);
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h5a5a}) begin
      errors++;
      $display("FAIL stall_ack: ack=%b rdata=%h expected 1/5a5a", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    for (int c = 11; c < 17; c++) cyc(16'(c), 16'd32);
    checks++;
    if (vid_cell !== 16'h1234) begin
      errors++;
      $display("FAIL stall_vid: got %h expected 1234", vid_cell);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d [4] = '{16'h0148, 16'h0265, 16'h1234, 16'h5a5a};
    logic [15:0] col = 16'd200;
    cyc(col, 16'd500);
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'(160 + i);
      #1;
      checks++;
      if ({ram_we, ram_addr, cpu_ack} !== {1'b0, 12'(160 + i), 1'b0}) begin
        errors++;
        $display("FAIL b2b_issue%0d: we=%b addr=%0d ack=%b expected 0/%0d/0", i, ram_we, ram_addr, cpu_ack, 160 + i);
      end
      col++;
      cyc(col, 16'd500);
      checks++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, d[i]}) begin
        errors++;
        $display("FAIL b2b_ack%0d: ack=%b rdata=%h expected 1/%h", i, cpu_ack, cpu_rdata, d[i]);
      end
      cpu_req = 1'b0;
      col++;
      cyc(col, 16'd500);
    end
  endtask

  task automatic test_reset_in_resp();
    int ack_seen = 0;
    cyc(16'd3, 16'd32);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd5; cpu_wdata = 16'habcd;
    #1;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL rr_issue: we=%b expected 1", ram_we);
    end
    @(posedge pixel_clk);
    data_reset_n = 1'b0;
    #1;
    checks++;
    if ({cpu_ack, cpu_rdata, vid_cell, ram_we, ram_addr, ram_wdata} !== 62'd0) begin
      errors++;
      $display("FAIL rr_clear: ack=%b rdata=%h vid=%h we=%b addr=%0d wdata=%h expected all 0",
               cpu_ack, cpu_rdata, vid_cell, ram_we, ram_addr, ram_wdata);
    end
    repeat (3) begin
      @(posedge pixel_clk);
      #1;
      if (cpu_ack) ack_seen++;
    end
    checks++;
    if (ack_seen !== 0) begin
      errors++;
      $display("FAIL rr_no_ack: ack cycles=%0d expected 0", ack_seen);
    end
    @(posedge pixel_clk);
    #1;
    data_reset_n = 1'b1;
    pixel_col = 16'd640; pixel_row = 16'd32;
    #1;
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'd5, 16'habcd}) begin
      errors++;
      $display("FAIL rr_reissue: we=%b addr=%0d wdata=%h expected 1/5/abcd", ram_we, ram_addr, ram_wdata);
    end
    cyc(16'd641, 16'd32);
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL rr_ack: ack=%b expected 1", cpu_ack);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    cyc(16'd0, 16'd32);
    checks++;
    if ({ram_we, ram_addr} !== {1'b0, 12'd161}) begin
      errors++;
      $display("FAIL rr_first_slot: we=%b addr=%0d expected 0/161", ram_we, ram_addr);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_load();
    test_fetch();
    test_wrap();
    test_resp_slot();
    test_stall();
    test_back_to_back();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
